jericalla_fetch: RTL and testbench
==================================

# jericalla_fetch

Instruction sequencer that drives the 17-bit `instruction` input of the Jericalla Evolution datapath. It holds a small program memory loaded through a write port and steps a program counter through it on command. It issues one instruction per clock and inserts NOP bubbles on stall. It replaces hand-fed instruction streams with a self-running program source.

## Interface
Parameters:
- `IW`, 17: instruction width (op[16:15], RA1[14:10], RA2[9:5], WA[4:0]).
- `DEPTH`, 64: program memory words.
- `AW`, 6: address width, equal to log2(DEPTH).
- `NOP`, 17'b0: value driven on `instruction` whenever no instruction is issued.

Ports:
- `CLK`  in  1  rising-edge clock.
- `RST_N`  in  1  asynchronous active-low reset.
- `load_en`  in  1  program write strobe.
- `load_addr`  in  AW  program write address.
- `load_data`  in  IW  program write data.
- `prog_len`  in  AW+1  number of instructions to run; sampled on start.
- `start`  in  1  begin execution from address 0.
- `stall`  in  1  hold the PC and issue a NOP this cycle.
- `halt`  in  1  abort the run.
- `instruction`  out  IW  registered instruction to the datapath.
- `instr_valid`  out  1  `instruction` is a real program word this cycle.
- `pc`  out  AW  address of the next word to issue.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE (level).

## Operation
- Memory is a DEPTH×IW register array with combinational read. It is not reset.
- A write occurs on any rising edge with `load_en`=1 in IDLE or DONE. Writes in RUN are ignored.
- State machine (IDLE, RUN, DONE), evaluated on each rising edge:
  - IDLE or DONE:
    - `halt`=1: stay in the current state; `start` is ignored.
    - `start`=1 and `prog_len`≠0: go to RUN; pc←0; len_r←min(`prog_len`, DEPTH).
    - `start`=1 and `prog_len`=0: go to DONE without issuing.
  - RUN:
    - `halt`=1: go to DONE; issue nothing (NOP, valid 0). `halt` has priority over `stall`.
    - `stall`=1: hold pc; instruction←NOP; instr_valid←0.
    - Otherwise: instruction←mem[pc]; instr_valid←1; pc←pc+1.
    - If the issued pc equals len_r−1: go to DONE on the same edge, and pc wraps to 0 when len_r=DEPTH.
  - In any edge that does not issue, instruction←NOP and instr_valid←0.
- A restart from DONE clears `done` on the accepting edge.
- A load and a start in the same IDLE cycle are both honoured. The written word is visible to the first issue.
- `busy` and `done` are decoded from state registers, so they carry no combinational path from inputs.

## Timing
- Reset values: state=IDLE, pc=0, instruction=NOP, instr_valid=0, busy=0, done=0.
- Reset asserted mid-run aborts immediately. Memory contents survive reset.
- Start latency: `start` sampled at edge k puts the FSM in RUN after edge k. The first word is registered at edge k+1 (instr_valid high from k+1 to k+2).
- Throughput: one instruction per unstalled cycle. A run of N words with S stall cycles spends N+S cycles in RUN.
- The last word is issued at the same edge that asserts `done`. `instr_valid` drops at the following edge.
- `stall` sampled high at edge m produces a NOP during cycle m to m+1; pc is unchanged.
- `prog_len` > DEPTH is clamped, so the run issues exactly DEPTH words, pc wraps to 0, and there is no over-read.

## Test plan
- Reset and load: hold RST_N=0, then release. Check all outputs at reset values. Load the four words 17'b00001000000100000, 17'b01001010000100010, 17'b10001100001000011, 17'b11000000011100100 to addresses 0-3.
- Basic run: with the four words loaded, prog_len=4, pulse start at edge k. Require instruction = words 0..3 at edges k+1..k+4 with instr_valid=1; done=1 after k+4; instruction=NOP and valid=0 after k+5.
- Stall: repeat the basic run with stall=1 at edge k+2 only. Require word1 at k+2+1 (the sequence is 0, NOP, 1, 2, 3) and pc held at 1 during the stall.
- Halt: during a run of prog_len=4, assert halt at the edge that would issue word 2. Require NOP with valid 0, done=1, and no further words; start with halt=1 in DONE is ignored.
- Edge lengths: prog_len=0 with start gives done=1 the next cycle and zero issues. prog_len=127 gives exactly 64 issues, pc wraps to 0, then done.
- Load during RUN and restart: a write in RUN leaves memory unchanged. A load plus start in the same IDLE cycle issues the newly written word first. Reset at edge k+2 of a run returns to IDLE with NOP, and a rerun after reset reissues the program intact.

Source files
------------

// File: rtl/jericalla_fetch.sv
// jericalla_fetch: self-running instruction source for the Jericalla Evolution
// datapath. A small program memory is filled through a write port. On start,
// the program counter walks it one word per clock. Stall inserts NOP bubbles
// and halt aborts the run.
module jericalla_fetch #(
  parameter int              IW    = 17,
  parameter int              DEPTH = 64,
  parameter int              AW    = 6,
  parameter logic [IW-1:0]   NOP   = '0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Full memory size expressed in the run-length width, used for clamping.
  localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] rd_word;
  logic          mem_we;
  logic          last_issue;
  logic [AW:0]   len_clamped;

  // Writes are accepted only while no program is running, so a run always
  // sees a stable program.
  assign mem_we = load_en && (state_q != S_RUN);

  // Program memory write port; contents are deliberately not reset so a
  // program survives a reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Combinational read at the current pc; the issued word is registered below.
  assign rd_word = mem_q[pc_q];

  // Requested length, limited to the memory size so a run never over-reads.
  assign len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;

  // The word being issued this edge is the final one of the run. len_q is
  // never zero in RUN, so the subtraction cannot underflow there.
  assign last_issue = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  // Next-state logic: sequencing, stall bubbles and halt handling.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = NOP;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // halt blocks any start while parked
        if (!halt && start) begin
          if (prog_len != '0) begin
            state_d = S_RUN;
            pc_d    = '0;
            len_d   = len_clamped;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (halt) begin
          // abort: nothing issued, pc left where it was
          state_d = S_DONE;
        end else if (!stall) begin
          instr_d = rd_word;
          valid_d = 1'b1;
          // natural AW-bit wrap returns pc to 0 after a full-depth run
          pc_d    = pc_q + AW'(1);
          if (last_issue) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_jericalla_fetch.sv
// Bench for jericalla_fetch: directed scenarios followed by randomized runs,
// every cycle compared against a per-edge behavioural model of the sequencer.
module tb_jericalla_fetch;

  logic        CLK;
  logic        RST_N;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [16:0] load_data;
  logic [6:0]  prog_len;
  logic        start;
  logic        stall;
  logic        halt;
  logic [16:0] instruction;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: program image plus run bookkeeping in plain ints.
  logic [16:0] mmem [64];
  bit          m_running;
  bit          m_finished;
  int          m_next;     // index of next word to issue
  int          m_len;      // words in this run
  logic [16:0] m_instr;
  bit          m_valid;

  logic [16:0] words [4];

  jericalla_fetch dut (
    .CLK(CLK), .RST_N(RST_N),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .stall(stall), .halt(halt),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_running  = 0;
    m_finished = 0;
    m_next     = 0;
    m_len      = 0;
    m_instr    = 17'd0;
    m_valid    = 0;
  endtask

  // One rising edge of the sequencer, applied to the inputs currently driven.
  task automatic model_edge();
    m_instr = 17'd0;
    m_valid = 0;
    if (!m_running) begin
      if (load_en) mmem[load_addr] = load_data;
      if (!halt && start) begin
        if (prog_len != 0) begin
          m_running  = 1;
          m_finished = 0;
          m_next     = 0;
          m_len      = (int'(prog_len) > 64) ? 64 : int'(prog_len);
        end else begin
          m_finished = 1;
        end
      end
    end else if (halt) begin
      m_running  = 0;
      m_finished = 1;
    end else if (!stall) begin
      m_instr = mmem[m_next];
      m_valid = 1;
      if (m_next == m_len - 1) begin
        m_running  = 0;
        m_finished = 1;
      end
      m_next = (m_next + 1) % 64;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".instruction"}, instruction, m_instr);
    check({tag, ".instr_valid"}, instr_valid, m_valid);
    check({tag, ".pc"},          pc,          m_next[5:0]);
    check({tag, ".busy"},        busy,        m_running);
    check({tag, ".done"},        done,        m_finished);
  endtask

  // Drive one cycle of inputs, clock it, then compare away from the edge.
  task automatic step(input string tag, input bit le, input logic [5:0] la,
                      input logic [16:0] ld, input logic [6:0] pl,
                      input bit st, input bit sl, input bit hl);
    load_en = le; load_addr = la; load_data = ld;
    prog_len = pl; start = st; stall = sl; halt = hl;
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
    $display("step %s: le=%0b st=%0b sl=%0b hl=%0b len=%0d -> instr=0x%05h v=%0b pc=%0d busy=%0b done=%0b",
             tag, le, st, sl, hl, pl, instruction, instr_valid, pc, busy, done);
    load_en = 0; start = 0; stall = 0; halt = 0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 6'd0, 17'd0, 7'd0, 0, 0, 0);
  endtask

  initial begin
    int issues;
    words[0] = 17'b00001000000100000;
    words[1] = 17'b01001010000100010;
    words[2] = 17'b10001100001000011;
    words[3] = 17'b11000000011100100;
    for (int i = 0; i < 64; i++) mmem[i] = 17'bx;

    RST_N = 1'b0; load_en = 0; load_addr = 0; load_data = 0;
    prog_len = 0; start = 0; stall = 0; halt = 0;
    model_reset();
    #12;
    check_all("reset");
    RST_N = 1'b1;
    idle("post_reset", 1);

    // Load the four program words
    for (int i = 0; i < 4; i++) step("load", 1, 6'(i), words[i], 7'd0, 0, 0, 0);

    // Basic run: words 0..3 then done, then NOP
    step("basic.start", 0, 6'd0, 17'd0, 7'd4, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle("basic.issue", 1);
      check("basic.word", instruction, words[i]);
    end
    check("basic.done", done, 1'b1);
    idle("basic.after", 1);
    check("basic.nop", instruction, 17'd0);

    // Stall at k+2: sequence 0, NOP, 1, 2, 3
    step("stall.start", 0, 6'd0, 17'd0, 7'd4, 1, 0, 0);
    idle("stall.w0", 1);
    step("stall.bubble", 0, 6'd0, 17'd0, 7'd0, 0, 1, 0);
    check("stall.pc_held", pc, 6'd1);
    idle("stall.w1", 1);
    check("stall.word1", instruction, words[1]);
    idle("stall.rest", 3);

    // Halt at the edge that would issue word 2; halt also wins over stall
    step("halt.start", 0, 6'd0, 17'd0, 7'd4, 1, 0, 0);
    idle("halt.w01", 2);
    step("halt.abort", 0, 6'd0, 17'd0, 7'd0, 0, 1, 1);
    check("halt.valid", instr_valid, 1'b0);
    idle("halt.after", 2);
    step("halt.start_ignored", 0, 6'd0, 17'd0, 7'd4, 1, 0, 1);
    idle("halt.parked", 1);

    // Zero-length run
    step("len0.start", 0, 6'd0, 17'd0, 7'd0, 1, 0, 0);
    idle("len0.after", 2);

    // Fill the whole memory, then an over-long run clamps to 64 issues
    for (int i = 0; i < 64; i++) step("fill", 1, 6'(i), (i < 4) ? words[i] : 17'($urandom), 7'd0, 0, 0, 0);
    step("len127.start", 0, 6'd0, 17'd0, 7'd127, 1, 0, 0);
    issues = 0;
    for (int c = 0; c < 70; c++) begin
      idle("len127.run", 1);
      if (instr_valid === 1'b1) issues++;
    end
    check("len127.issues", issues, 64);
    check("len127.pc_wrap", pc, 6'd0);
    check("len127.done", done, 1'b1);

    // A write during RUN must not land; rerun shows original word 1
    step("runwr.start", 0, 6'd0, 17'd0, 7'd4, 1, 0, 0);
    step("runwr.write", 1, 6'd1, 17'h1ABCD, 7'd0, 0, 0, 0);
    idle("runwr.rest", 4);
    step("runwr.rerun", 0, 6'd0, 17'd0, 7'd4, 1, 0, 0);
    idle("runwr.w0", 1);
    idle("runwr.w1", 1);
    check("runwr.word1", instruction, words[1]);
    idle("runwr.rest2", 3);

    // Reset in the middle of a run
    step("rst.start", 0, 6'd0, 17'd0, 7'd4, 1, 0, 0);
    idle("rst.w0", 1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all("rst.mid");
    @(posedge CLK);
    #1;
    check_all("rst.hold");
    RST_N = 1'b1;

    // Load plus start in the same IDLE cycle: new word issues first
    step("ldst.both", 1, 6'd0, 17'h15A5A, 7'd4, 1, 0, 0);
    idle("ldst.w0", 1);
    check("ldst.newword", instruction, 17'h15A5A);
    idle("ldst.rest", 4);
    step("rerun.start", 0, 6'd0, 17'd0, 7'd4, 1, 0, 0);
    idle("rerun.run", 5);

    // Randomized runs with stalls, rare halts and ignored writes/starts
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3)) step("rnd.load", 1, 6'($urandom), 17'($urandom), 7'd0, 0, 0, 0);
      step("rnd.start", 0, 6'd0, 17'd0, 7'($urandom_range(0, 80)), 1, 0, 0);
      for (int c = 0; c < 300 && m_running; c++)
        step("rnd.run", $urandom_range(0, 3) == 0, 6'($urandom), 17'($urandom), 7'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 50) == 0);
      idle("rnd.tail", 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
